weight_update: RTL
==================

Name: weight_update

Overview:
- Downstream stage of the backprop delta calculator. Holds the 3x5 output-layer weight matrix in registers.
- On a Start pulse it captures the three output deltas and the five hidden activations, then walks all 15 weights, one per cycle, computing w_new = w - lr * delta * act.
- It signals Done when the pass completes. The forward stage reads the weights through a combinational read port; software or bench preloads them through a write port.

Parameters:
- W, 10, data width of weights, deltas and activations (signed two's complement)
- FRAC, 8, fractional bits (Q2.8)
- N_IN, 5, hidden-layer activations per output
- N_OUT, 3, output neurons
- LR_SHIFT, 2, learning rate = 2^-LR_SHIFT

Ports:
- Clock  in  1  rising-edge clock
- Rst  in  1  synchronous, active-low reset
- Start  in  1  one-cycle request to run an update pass
- delta_in  in  N_OUT*W  deltas; delta j at bits [j*W +: W]
- act_in  in  N_IN*W  hidden activations; act i at bits [i*W +: W]
- WE  in  1  weight preload strobe
- wr_addr  in  4  preload address
- wr_data  in  W  preload value
- rd_addr  in  4  read address
- rd_data  out  W  weight at rd_addr (combinational)
- Busy  out  1  high while a pass is in progress
- Done  out  1  one-cycle pulse when a pass completes

Behaviour:
- Reset: taken when Rst=0 at a Clock edge. All 15 weights go to 0, FSM goes to IDLE, Busy=0, Done=0, index counters go to 0. Reset during UPDATE aborts the pass; partially updated weights are also cleared.
- Address map: addr = j*N_IN + i, for j = 0..2 and i = 0..4, giving 0..14.
  - wr_addr >= 15: write ignored.
  - rd_addr >= 15: rd_data = 0.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE: if Start=1, latch delta_in and act_in into internal registers, clear the index counters, go to UPDATE, Busy=1. Otherwise stay.
  - UPDATE: each cycle, update the weight at the current (j,i) and advance i. When i wraps from 4 to 0, j increments. After (j,i)=(2,4), go to DONE.
  - DONE: Done=1 and Busy=0 for exactly this cycle, then return to IDLE.
- Timing: Start sampled at edge 0; updates are written at edges 1..15; Done is high during the cycle after edge 15. Start is accepted again in the cycle after DONE.
- Start while Busy or in DONE is ignored; no queuing.
- Input capture: delta_in and act_in are captured only at Start acceptance. Changes during the pass have no effect.
- Update arithmetic, per weight:
  - p = signed(delta_j) * signed(act_i), 2W = 20 bits, Q4.16.
  - s = p >>> (FRAC + LR_SHIFT), arithmetic shift, which rounds toward minus infinity.
  - r = w - s, computed at 2W width.
  - Saturate r to [-512, +511], then write it back.
- Preload: WE=1 while IDLE writes wr_data to wr_addr at the edge. WE while Busy or in DONE is ignored; the FSM owns the array.
- rd_data is always the current register contents. During a pass it reflects weights already updated, so readers must wait for Done.
- Simultaneous Start and WE in IDLE: Start wins, the write is dropped, and the captured pass uses the pre-write weights.

Test Plan:
- Basic: preload addr 0 = 0x040 (+0.25). Start with delta0 = 0x100 (+1.0), act0 = 0x080 (+0.5), all other deltas and acts 0. Required: Busy high for edges 1..15, Done pulse at cycle 16, rd_data[0] = 0x020, every other weight unchanged.
- Negative delta: addr 5 = 0x040, delta1 = 0x300 (-1.0), act0 = 0x080. Required: rd_data[5] = 0x060 (+96).
- Floor rounding: delta0 = 0x001, act1 = 0x001, addr 1 = 0. Required: rd_data[1] = 0 (p >>> 10 = 0). Repeat with delta0 = 0x3FF (-1): rd_data[1] = 0x001.
- Saturation, both rails:
  - addr 14 = 0x1FF, delta2 = 0x200, act4 = 0x1FF. Required: rd_data[14] = 0x1FF, since r = 767 clips to 511.
  - addr 10 = 0x200, delta2 = 0x1FF, act0 = 0x1FF. Required: rd_data[10] = 0x200, since r = -767 clips to -512.
- Protocol:
  - Start pulsed again at cycle 5 of a pass: ignored, single Done.
  - WE to addr 3 mid-pass: no effect.
  - wr_addr = 15: no write.
  - rd_addr = 15: reads 0.
- Reset mid-pass: drive Rst=0 at cycle 7 of a pass. Required: next cycle Busy=0, Done=0, all rd_data reads 0. After release, a new Start runs a full 15-cycle pass.

Source files
------------

// File: rtl/weight_update.sv
// rtl/weight_update.sv - 3x5 output-layer weight matrix with a sequential
// one-weight-per-cycle update pass (w -= lr * delta * act, saturated).
module weight_update #(
  parameter int W        = 10,
  parameter int FRAC     = 8,
  parameter int N_IN     = 5,
  parameter int N_OUT    = 3,
  parameter int LR_SHIFT = 2
) (
  input  logic               Clock,
  input  logic               Rst,
  input  logic               Start,
  input  logic [N_OUT*W-1:0] delta_in,
  input  logic [N_IN*W-1:0]  act_in,
  input  logic               WE,
  input  logic [3:0]         wr_addr,
  input  logic [W-1:0]       wr_data,
  input  logic [3:0]         rd_addr,
  output logic [W-1:0]       rd_data,
  output logic               Busy,
  output logic               Done
);
  localparam int N_W = N_IN * N_OUT;
  localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [3:0] N_W_A = 4'(N_W);
  localparam logic signed [2*W-1:0] R_MAX = (2*W)'((2**(W-1)) - 1);
  localparam logic signed [2*W-1:0] R_MIN = (2*W)'(-(2**(W-1)));

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t state, state_next;

  logic signed [W-1:0] weights [N_W];
  logic signed [W-1:0] delta_q [N_OUT];
  logic signed [W-1:0] act_q   [N_IN];
  logic [JW-1:0]       j_q;
  logic [IW-1:0]       i_q;

  logic [3:0]            cur_addr;
  logic                  last;
  logic signed [W-1:0]   w_cur;
  logic signed [2*W-1:0] d_ext, a_ext, w_ext, prod, step, diff;
  logic signed [W-1:0]   w_new;

  // Datapath for the weight at (j_q, i_q); the product of two Q2.8 values fits 2W bits.
  always_comb begin
    cur_addr = 4'(int'(j_q) * N_IN + int'(i_q));
    last     = (j_q == JW'(N_OUT - 1)) && (i_q == IW'(N_IN - 1));
    w_cur    = weights[cur_addr];
    d_ext    = {{W{delta_q[j_q][W-1]}}, delta_q[j_q]};
    a_ext    = {{W{act_q[i_q][W-1]}}, act_q[i_q]};
    w_ext    = {{W{w_cur[W-1]}}, w_cur};
    prod     = d_ext * a_ext;
    step     = prod >>> (FRAC + LR_SHIFT);
    diff     = w_ext - step;
    if (diff > R_MAX)
      w_new = W'(R_MAX);
    else if (diff < R_MIN)
      w_new = W'(R_MIN);
    else
      w_new = diff[W-1:0];
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE:   if (Start) state_next = UPDATE;
      UPDATE: begin
        Busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE:   begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state <= IDLE;
      j_q   <= '0;
      i_q   <= '0;
      for (int k = 0; k < N_W; k++) weights[k] <= '0;
      for (int k = 0; k < N_OUT; k++) delta_q[k] <= '0;
      for (int k = 0; k < N_IN; k++) act_q[k] <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          // Start takes priority over a same-cycle preload.
          if (Start) begin
            for (int k = 0; k < N_OUT; k++) delta_q[k] <= delta_in[k*W +: W];
            for (int k = 0; k < N_IN; k++) act_q[k] <= act_in[k*W +: W];
            j_q <= '0;
            i_q <= '0;
          end else if (WE && (wr_addr < N_W_A)) begin
            weights[wr_addr] <= wr_data;
          end
        end
        UPDATE: begin
          weights[cur_addr] <= w_new;
          if (last) begin
            j_q <= '0;
            i_q <= '0;
          end else if (i_q == IW'(N_IN - 1)) begin
            i_q <= '0;
            j_q <= j_q + 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data = (rd_addr < N_W_A) ? weights[rd_addr] : '0;

endmodule
